async_fifo: RTL and testbench

Single-clock, first-in/first-out data buffer with an asynchronous active-low reset; "async" in the block name refers to the reset style. It sits between a producer and a consumer in the same clock domain. Both sides have a write/read strobe and full/empty status. The block registers read data and reports rejected accesses as single-cycle error pulses.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 54 +++++
 rtl/async_fifo.sv | 127 ++++++++++++
 tb/tb_async_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helpers for the single-clock FIFO.
// Used by async_fifo and fifo_mem.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Full: pointers agree on the address bits but differ in the wrap bit.
    function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                      input int asize);
        logic [31:0] diff;
        diff = (wptr ^ rptr) & ((32'd2 << asize) - 32'd1);
        return diff == (32'd1 << asize);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// 2^ASIZE x DSIZE register array: synchronous write port, registered read port.
// Array contents are not reset; only the read register is.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] mem_d [DEPTH];
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with asynchronous active-low reset, registered read data and
// one-cycle overflow/underflow pulses. FIFO_ASYNC_FORMAL_EN compiles in properties.
module async_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_wr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_rd,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_wfull,
    output logic             o_rempty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          wfull_q, wfull_d;
    logic          rempty_q, rempty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_ok, rd_ok;

    assign wr_ok = i_wr && !wfull_q;
    assign rd_ok = i_rd && !rempty_q;

    // Flags are derived from next-state pointers so they are exact one cycle after the access.
    always_comb begin
        wptr_d      = wptr_q + PW'(wr_ok);
        rptr_d      = rptr_q + PW'(rd_ok);
        rempty_d    = (wptr_d == rptr_d);
        wfull_d     = ptr_full(32'(wptr_d), 32'(rptr_d), ASIZE);
        overflow_d  = i_wr && wfull_q;
        underflow_d = i_rd && rempty_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .wr_en (wr_ok),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (i_wdata),
        .rd_en (rd_ok),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (o_rdata)
    );

    assign o_wfull     = wfull_q;
    assign o_rempty    = rempty_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

`ifdef FIFO_ASYNC_FORMAL_EN
    localparam logic [ASIZE-1:0] TRK_ADDR = '0;

    // Tracks the first word written to TRK_ADDR and the number of words queued ahead of it.
    logic             trk_armed_q, trk_chk_q;
    logic [DSIZE-1:0] trk_data_q;
    logic [PW-1:0]    trk_ahead_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            trk_armed_q <= 1'b0;
            trk_chk_q   <= 1'b0;
            trk_data_q  <= '0;
            trk_ahead_q <= '0;
        end else begin
            trk_chk_q <= 1'b0;
            if (!trk_armed_q && wr_ok && wptr_q[ASIZE-1:0] == TRK_ADDR) begin
                trk_armed_q <= 1'b1;
                trk_data_q  <= i_wdata;
                trk_ahead_q <= wptr_q - rptr_q - PW'(rd_ok);
            end else if (trk_armed_q && rd_ok) begin
                if (trk_ahead_q == '0) begin
                    trk_armed_q <= 1'b0;
                    trk_chk_q   <= 1'b1;
                end else begin
                    trk_ahead_q <= trk_ahead_q - PW'(1);
                end
            end
        end
    end

    a_flags_mutex: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(o_wfull && o_rempty));
    a_occupancy: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (wptr_q - rptr_q) <= PW'(1 << ASIZE));
    a_track_data: assert property (@(posedge i_clk) disable iff (!i_rstn)
        trk_chk_q |-> (o_rdata == trk_data_q));
    a_wr_reject: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (i_wr && o_wfull) |=> (wptr_q == $past(wptr_q)));
    a_rd_reject: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (i_rd && o_rempty) |=> (rptr_q == $past(rptr_q)));
    c_full: cover property (@(posedge i_clk) disable iff (!i_rstn) o_wfull);
    c_full_to_empty: cover property (@(posedge i_clk) disable iff (!i_rstn)
        o_wfull ##[1:$] o_rempty);
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue-based reference model predicts read data
// and flags; a negedge monitor pops expected read data and compares.
module tb_async_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             i_clk = 1'b0;
    logic             i_rstn = 1'b1;
    logic             i_wr = 1'b0;
    logic             i_rd = 1'b0;
    logic [DSIZE-1:0] i_wdata = '0;
    logic [DSIZE-1:0] o_rdata;
    logic             o_wfull, o_rempty, o_overflow, o_underflow;

    async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_wr        (i_wr),
        .i_wdata     (i_wdata),
        .i_rd        (i_rd),
        .o_rdata     (o_rdata),
        .o_wfull     (o_wfull),
        .o_rempty    (o_rempty),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] model_q [$];
    logic [DSIZE-1:0] exp_q [$];
    logic exp_empty = 1'b1, exp_full = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model advances with the same rules as the DUT should.
    task automatic cycle(input logic wr, input logic [DSIZE-1:0] d, input logic rd);
        int  cnt;
        logic wa, ra;
        i_wr = wr;
        i_wdata = d;
        i_rd = rd;
        @(posedge i_clk);
        cnt = model_q.size();
        wa = wr && (cnt < DEPTH);
        ra = rd && (cnt > 0);
        exp_ovf = wr && (cnt == DEPTH);
        exp_udf = rd && (cnt == 0);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        exp_empty = (model_q.size() == 0);
        exp_full = (model_q.size() == DEPTH);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0);
    endtask

    // Reset asserted away from the clock edge; optionally hold a write request throughout.
    task automatic do_reset(input logic hold_wr);
        #2;
        i_rstn = 1'b0;
        i_wr = hold_wr;
        i_wdata = 8'hA5;
        i_rd = 1'b0;
        model_q.delete();
        exp_q.delete();
        exp_empty = 1'b1;
        exp_full = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1;
        check("rst_rempty", o_rempty, 1);
        check("rst_wfull", o_wfull, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_underflow", o_underflow, 0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        i_wr = 1'b0;
    endtask

    initial begin : monitor
        logic             pending;
        logic [DSIZE-1:0] last, e;
        pending = 1'b0;
        last = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                pending = 1'b0;
                last = '0;
                check("rdata_in_reset", o_rdata, 0);
            end else begin
                if (pending) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL read_unexpected: got read data %0h, expected no read at t=%0t",
                                 o_rdata, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", o_rdata, e);
                        last = e;
                    end
                end else begin
                    check("rdata_hold", o_rdata, last);
                end
                pending = i_rd && !o_rempty;
            end
            check("rempty", o_rempty, exp_empty);
            check("wfull", o_wfull, exp_full);
            check("overflow", o_overflow, exp_ovf);
            check("underflow", o_underflow, exp_udf);
        end
    end

    initial begin : stimulus
        int written;
        do_reset(1'b1);
        idle(1);

        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        idle(2);

        cycle(1'b0, '0, 1'b1);
        idle(2);

        for (int k = 0; k < DEPTH; k++) cycle(1'b1, DSIZE'($urandom), 1'b0);
        idle(1);
        cycle(1'b1, 8'hEE, 1'b0);
        idle(1);
        cycle(1'b1, 8'hDD, 1'b1);
        idle(1);
        repeat (DEPTH) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        idle(2);

        written = 0;
        for (int k = 0; k < 400 && written < 40; k++) begin
            logic wr;
            wr = ($urandom_range(0, 3) != 0);
            if (wr && model_q.size() < DEPTH) written++;
            cycle(wr, DSIZE'($urandom), $urandom_range(0, 1) == 1);
        end
        check("stream_words_written", written, 40);
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
        idle(2);

        for (int k = 0; k < 25; k++) cycle($urandom_range(0, 3) != 0, DSIZE'($urandom), $urandom_range(0, 2) == 0);
        do_reset(1'b0);
        cycle(1'b0, '0, 1'b1);
        for (int k = 0; k < 300; k++) cycle($urandom_range(0, 1) == 1, DSIZE'($urandom), $urandom_range(0, 1) == 1);
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
